// File: rtl/ula_controle.sv
`timescale 1ns/1ps
// Command-stream front end for an external ULA: parses header/A/B packets, drives the
// operands, waits ULA_LAT edges, captures the result and holds it until accepted downstream.
module ula_controle #(
  parameter int unsigned ULA_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_dado,
  input  logic       in_valido,
  output logic       in_pronto,
  output logic [7:0] ula_a,
  output logic [7:0] ula_b,
  output logic [2:0] ula_opcode,
  input  logic [7:0] ula_s,
  output logic [7:0] res_dado,
  output logic       res_valido,
  input  logic       res_pronto,
  output logic       erro,
  output logic [7:0] contador
);

  typedef enum logic [2:0] {
    OCIOSO,
    LE_A,
    LE_B,
    EXEC,
    RESULTADO
  } estado_t;

  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] LAT_INI = 3'(ULA_LAT);

  estado_t    estado_q, estado_d;
  logic [2:0] op_pend_q, op_pend_d;
  logic [7:0] a_pend_q, a_pend_d;
  logic [7:0] ula_a_q, ula_a_d;
  logic [7:0] ula_b_q, ula_b_d;
  logic [2:0] ula_op_q, ula_op_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] res_q, res_d;
  logic       erro_q, erro_d;
  logic [7:0] cont_q, cont_d;

  // Header opcode and operand A are held in pending registers so the ULA inputs only
  // change once the whole packet has arrived.
  always_comb begin
    estado_d   = estado_q;
    op_pend_d  = op_pend_q;
    a_pend_d   = a_pend_q;
    ula_a_d    = ula_a_q;
    ula_b_d    = ula_b_q;
    ula_op_d   = ula_op_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    erro_d     = erro_q;
    cont_d     = cont_q;
    in_pronto  = 1'b0;
    res_valido = 1'b0;

    case (estado_q)
      OCIOSO: begin
        in_pronto = 1'b1;
        if (in_valido) begin
          if (in_dado[7:3] == 5'd0) begin
            op_pend_d = in_dado[2:0];
            estado_d  = LE_A;
          end else begin
            erro_d = 1'b1;
          end
        end
      end

      LE_A: begin
        in_pronto = 1'b1;
        if (in_valido) begin
          if (op_pend_q == OP_NOT) begin
            ula_a_d  = in_dado;
            ula_b_d  = 8'h00;
            ula_op_d = op_pend_q;
            cnt_d    = LAT_INI;
            estado_d = EXEC;
          end else begin
            a_pend_d = in_dado;
            estado_d = LE_B;
          end
        end
      end

      LE_B: begin
        in_pronto = 1'b1;
        if (in_valido) begin
          ula_a_d  = a_pend_q;
          ula_b_d  = in_dado;
          ula_op_d = op_pend_q;
          cnt_d    = LAT_INI;
          estado_d = EXEC;
        end
      end

      EXEC: begin
        if (cnt_q == 3'd0) begin
          res_d    = ula_s;
          estado_d = RESULTADO;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      RESULTADO: begin
        res_valido = 1'b1;
        if (res_pronto) begin
          cont_d   = cont_q + 8'd1;
          estado_d = OCIOSO;
        end
      end

      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      op_pend_q <= 3'b000;
      a_pend_q  <= 8'h00;
      ula_a_q   <= 8'h00;
      ula_b_q   <= 8'h00;
      ula_op_q  <= 3'b000;
      cnt_q     <= 3'd0;
      res_q     <= 8'h00;
      erro_q    <= 1'b0;
      cont_q    <= 8'h00;
    end else begin
      estado_q  <= estado_d;
      op_pend_q <= op_pend_d;
      a_pend_q  <= a_pend_d;
      ula_a_q   <= ula_a_d;
      ula_b_q   <= ula_b_d;
      ula_op_q  <= ula_op_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      erro_q    <= erro_d;
      cont_q    <= cont_d;
    end
  end

  assign ula_a      = ula_a_q;
  assign ula_b      = ula_b_q;
  assign ula_opcode = ula_op_q;
  assign res_dado   = res_q;
  assign erro       = erro_q;
  assign contador   = cont_q;

endmodule

// File: doc/ula_controle.md
ULA_CONTROLE -- requirements
Module: ula_controle

Interface
REQ-001 The block SHALL have parameter ULA_LAT, default 1, meaning clock edges between ula_a/ula_b/ula_opcode settling and ula_s being valid (range 0..7).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, with synchronous, active-high reset.
REQ-004 The block SHALL have port in_dado, input, 8, the command byte stream.
REQ-005 The block SHALL have port in_valido, input, 1, meaning in_dado is valid.
REQ-006 The block SHALL have port in_pronto, output, 1, meaning the block accepts a byte this cycle.
REQ-007 The block SHALL have port ula_a, output, 8, operand A to the ULA.
REQ-008 The block SHALL have port ula_b, output, 8, operand B to the ULA.
REQ-009 The block SHALL have port ula_opcode, output, 3, the ULA operation.
REQ-010 The block SHALL have port ula_s, input, 8, the ULA result.
REQ-011 The block SHALL have port res_dado, output, 8, the captured result.
REQ-012 The block SHALL have port res_valido, output, 1, meaning res_dado is valid.
REQ-013 The block SHALL have port res_pronto, input, 1, meaning downstream accepts the result.
REQ-014 The block SHALL have port erro, output, 1, a sticky bad-header flag.
REQ-015 The block SHALL have port contador, output, 8, the count of delivered results.

Function
REQ-016 A byte transfer SHALL occur only on a rising edge with in_valido=1 and in_pronto=1; a result transfer SHALL occur only with res_valido=1 and res_pronto=1.
REQ-017 Packet format SHALL be: header (bits[2:0]=opcode, bits[7:3]=0), then A, then B; opcode 3'b101 (NOT) SHALL have no B byte.
REQ-018 The FSM SHALL have exactly five states: OCIOSO, LE_A, LE_B, EXEC, RESULTADO.
REQ-019 in_pronto SHALL be 1 exactly in OCIOSO, LE_A and LE_B; res_valido SHALL be 1 exactly in RESULTADO.
REQ-020 OCIOSO: on a header transfer with bits[7:3]=0, the block SHALL latch the opcode and go to LE_A; with bits[7:3]≠0 it SHALL drop the byte, set erro=1 on that edge, and stay in OCIOSO.
REQ-021 LE_A: on transfer, the block SHALL latch A; for opcode 101 it SHALL go to EXEC with B forced to 8'h00, otherwise it SHALL go to LE_B.
REQ-022 LE_B: on transfer, the block SHALL latch B and go to EXEC.
REQ-023 ula_a, ula_b and ula_opcode SHALL update on the edge that enters EXEC and SHALL remain stable through EXEC and RESULTADO until the next packet's operand latches.
REQ-024 On entering EXEC, a 3-bit counter SHALL load ULA_LAT.
REQ-025 In each EXEC cycle, if the counter is 0 the block SHALL capture ula_s into res_dado and go to RESULTADO; otherwise it SHALL decrement the counter.
REQ-026 Latency: ula_s SHALL be captured ULA_LAT+1 edges after the last operand byte edge, and res_valido SHALL rise the cycle after capture.
REQ-027 RESULTADO: res_dado SHALL hold stable while res_pronto=0, with no timeout.
REQ-028 On a result transfer, contador SHALL increment mod 256 (255→0) and the FSM SHALL go to OCIOSO; in_pronto SHALL return one cycle later, with no overlap.
REQ-029 in_dado with in_valido=0 SHALL be ignored in every state; in_valido in EXEC or RESULTADO SHALL be ignored and not consumed.
REQ-030 erro SHALL not block operation: the next valid header SHALL be accepted normally.

Reset
REQ-031 With rst=1 at an edge, from any state, the block SHALL go to OCIOSO and discard any partial packet or pending result.
REQ-032 Reset values SHALL be: in_pronto=1 after reset; ula_a, ula_b, res_dado and contador 8'h00; ula_opcode 3'b000; res_valido=0; erro=0.
REQ-033 rst SHALL take priority over any simultaneous byte or result transfer; that transfer SHALL not count.

Verification
REQ-034 ADD: ULA_LAT=1, bytes 00,05,0A, res_pronto=1 → res_dado=8'h0F, contador=1, res_valido rising exactly 3 edges after the B byte edge.
REQ-035 NOT with backpressure: bytes 05,F0, res_pronto=0 for 10 cycles → ula_b=00, res_dado=8'h0F held stable for all 10 cycles, in_pronto=0 throughout, exactly 1 result after release.
REQ-036 Bad header: byte 0D → erro=1, no result, in_pronto stays 1; then 02,CA,AC → res_dado=8'h88 and erro still 1.
REQ-037 Reset mid-packet: 01,0F then rst, then 04,CA,AC → exactly one result, res_dado=8'h66, erro=0, contador=1.
REQ-038 Wrap: 256 back-to-back SUB packets 01,0F,0A → every res_dado=8'h05, contador returns to 8'h00.
REQ-039 in_valido gaps between bytes → results identical to the gap-free case.
